// File: rtl/sim_fetch_ctrl.sv
// Fetch sequencer between a PC predictor and the sim_intf reference model.
// Accepts candidate PCs over valid/ready, probes sim_intf one PC per cycle,
// queues confirmed instructions in a small FIFO and redirects the predictor
// on a miss.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_pc/req_ready     candidate PC channel from the predictor
//   flush/redirect_pc              one-cycle restart pulse to the predictor
//   probe_en/pc_try                probe to sim_intf
//   pc_factual/insn/miss           sim_intf response for the current probe
//   out_valid/out_pc/out_insn      committed instruction (FIFO head)
//   out_ready                      consumer pop
//   hit_count/miss_count           saturating probe statistics
module sim_fetch_ctrl #(
  parameter logic [63:0] START_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [63:0] req_pc,
  output logic        req_ready,
  output logic        flush,
  output logic [63:0] redirect_pc,
  output logic        probe_en,
  output logic [63:0] pc_try,
  input  logic [63:0] pc_factual,
  input  logic [31:0] insn,
  input  logic        miss,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_insn,
  input  logic        out_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_t;

  state_t state, nxt_state;

  logic [63:0] mem_pc   [FIFO_DEPTH];
  logic [31:0] mem_insn [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, nxt_rd, nxt_wr;
  logic [CNT_W-1:0] count, nxt_count;

  logic        nxt_probe_en, nxt_flush, nxt_req_ready, nxt_out_valid;
  logic [63:0] nxt_pc_try, nxt_redirect, nxt_out_pc;
  logic [31:0] nxt_out_insn, nxt_hit_count, nxt_miss_count;
  logic        push, pop, hit, mis, accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= nxt_state;
  end

  // Next-state and next-output logic
  always_comb begin
    nxt_state      = state;
    nxt_probe_en   = 1'b0;
    nxt_pc_try     = pc_try;
    nxt_flush      = 1'b0;
    nxt_redirect   = redirect_pc;
    accept         = 1'b0;
    push           = 1'b0;
    hit            = 1'b0;
    mis            = 1'b0;
    pop            = out_valid && out_ready;
    nxt_out_pc     = out_pc;
    nxt_out_insn   = out_insn;

    // Probe resolution; sim_intf inputs are only meaningful while probing
    if (probe_en) begin
      if (!miss) begin
        push = 1'b1;
        hit  = 1'b1;
      end else begin
        mis  = 1'b1;
      end
    end

    case (state)
      // Registered flush rises on the first edge out of reset, then RUN
      ST_BOOT: begin
        nxt_redirect = START_PC;
        if (flush) nxt_state = ST_RUN;
        else       nxt_flush = 1'b1;
      end
      ST_RUN: begin
        accept = req_valid && req_ready;
        if (accept) begin
          nxt_probe_en = 1'b1;
          nxt_pc_try   = req_pc;
        end
        // A miss squashes whatever was accepted alongside it
        if (mis) begin
          nxt_probe_en = 1'b0;
          nxt_redirect = pc_factual;
          nxt_flush    = 1'b1;
          nxt_state    = ST_FLUSH;
        end
      end
      ST_FLUSH: nxt_state = ST_RUN;
      default:  nxt_state = ST_BOOT;
    endcase

    nxt_rd    = rd_ptr + PTR_W'(pop);
    nxt_wr    = wr_ptr + PTR_W'(push);
    nxt_count = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));

    // One slot is reserved for every probe in flight
    nxt_req_ready = (nxt_state == ST_RUN) &&
                    ((32'(nxt_count) + 32'(nxt_probe_en)) < FIFO_DEPTH);

    // Head register: the pushed entry becomes head when it lands in an empty queue
    nxt_out_valid = (nxt_count != '0);
    if (push && (nxt_count == CNT_W'(1))) begin
      nxt_out_pc   = pc_try;
      nxt_out_insn = insn;
    end else if (nxt_count != '0) begin
      nxt_out_pc   = mem_pc[nxt_rd];
      nxt_out_insn = mem_insn[nxt_rd];
    end

    nxt_hit_count  = (hit && (hit_count != 32'hFFFF_FFFF)) ? hit_count + 32'd1 : hit_count;
    nxt_miss_count = (mis && (miss_count != 32'hFFFF_FFFF)) ? miss_count + 32'd1 : miss_count;
  end

  // Registered outputs and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_en    <= 1'b0;
      pc_try      <= '0;
      req_ready   <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= START_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_insn    <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      probe_en    <= nxt_probe_en;
      pc_try      <= nxt_pc_try;
      req_ready   <= nxt_req_ready;
      flush       <= nxt_flush;
      redirect_pc <= nxt_redirect;
      rd_ptr      <= nxt_rd;
      wr_ptr      <= nxt_wr;
      count       <= nxt_count;
      out_valid   <= nxt_out_valid;
      out_pc      <= nxt_out_pc;
      out_insn    <= nxt_out_insn;
      hit_count   <= nxt_hit_count;
      miss_count  <= nxt_miss_count;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= pc_try;
      mem_insn[wr_ptr] <= insn;
    end
  end

endmodule

// File: tb/tb_sim_fetch_ctrl.sv
// Randomized bench for sim_fetch_ctrl: a predictor and sim_intf stand-in drive
// the DUT; a transaction-level reference model predicts every output.
module tb_sim_fetch_ctrl;

  localparam logic [63:0] START = 64'h0000_0000_8000_0000;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [63:0] req_pc = '0;
  logic        req_ready;
  logic        flush;
  logic [63:0] redirect_pc;
  logic        probe_en;
  logic [63:0] pc_try;
  logic [63:0] pc_factual = '0;
  logic [31:0] insn = '0;
  logic        miss = 1'b0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_insn;
  logic        out_ready = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  sim_fetch_ctrl #(.START_PC(START), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .flush(flush), .redirect_pc(redirect_pc),
    .probe_en(probe_en), .pc_try(pc_try),
    .pc_factual(pc_factual), .insn(insn), .miss(miss),
    .out_valid(out_valid), .out_pc(out_pc), .out_insn(out_insn), .out_ready(out_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: architectural PC stream, expected FIFO contents as a queue
  logic [63:0] arch_pc, pred_pc, m_pc, m_redirect;
  bit          m_probe, m_flush;
  int          m_boot;
  int unsigned m_hit, m_miss;
  logic [95:0] q[$];

  function automatic logic [31:0] insn_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hDEAD_BEEF ^ {pc[15:0], pc[31:16]};
  endfunction

  function automatic bit exp_ready();
    return (m_boot == 0) && !m_flush && ((q.size() + int'(m_probe)) < int'(DEPTH));
  endfunction

  function automatic bit exp_flush();
    return m_flush || (m_boot == 1);
  endfunction

  task automatic model_reset();
    arch_pc = START; pred_pc = START; m_pc = '0; m_redirect = START;
    m_probe = 0; m_flush = 0; m_boot = 2; m_hit = 0; m_miss = 0;
    q.delete();
  endtask

  task automatic check_all();
    logic [95:0] head;
    check("flush", 64'(flush), 64'(exp_flush()));
    check("req_ready", 64'(req_ready), 64'(exp_ready()));
    check("probe_en", 64'(probe_en), 64'(m_probe));
    if (m_probe) check("pc_try", pc_try, m_pc);
    if (exp_flush()) check("redirect_pc", redirect_pc, m_redirect);
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      head = q[0];
      check("out_pc", out_pc, head[95:32]);
      check("out_insn", 64'(out_insn), 64'(head[31:0]));
    end
    check("hit_count", 64'(hit_count), 64'(m_hit));
    check("miss_count", 64'(miss_count), 64'(m_miss));
  endtask

  task automatic check_reset_values();
    check("rst_probe_en", 64'(probe_en), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_pc_try", pc_try, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_insn", 64'(out_insn), 64'd0);
    check("rst_redirect", redirect_pc, START);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_miss_count", 64'(miss_count), 64'd0);
  endtask

  // Drive the environment for the coming edge and advance the model across it
  task automatic drive_and_step(input int rdy_pct);
    bit acc, pop, hit, missed;
    if (m_probe) begin
      insn       = insn_of(m_pc);
      miss       = (m_pc != arch_pc);
      pc_factual = arch_pc;
    end else begin
      insn       = $urandom;
      miss       = 1'($urandom_range(0, 1));
      pc_factual = {$urandom, $urandom};
    end
    if (exp_flush()) pred_pc = m_redirect;
    req_valid = ($urandom_range(0, 99) < 80);
    req_pc    = ($urandom_range(0, 99) < 12) ? (pred_pc ^ 64'h0000_0000_AAAA_0000) : pred_pc;
    out_ready = ($urandom_range(0, 99) < rdy_pct);

    acc    = exp_ready() && req_valid;
    pop    = (q.size() != 0) && out_ready;
    hit    = m_probe && (m_pc == arch_pc);
    missed = m_probe && !hit;
    if (acc) pred_pc = pred_pc + 64'd4;
    if (pop) void'(q.pop_front());
    if (hit) begin
      q.push_back({m_pc, insn_of(m_pc)});
      arch_pc = arch_pc + 64'd4;
      m_hit++;
    end
    if (missed) begin
      m_miss++;
      m_redirect = arch_pc;
    end
    m_flush = missed;
    m_probe = acc && !missed;
    if (m_probe) m_pc = req_pc;
    if (m_boot > 0) m_boot--;
  endtask

  task automatic release_reset(input int rdy_pct);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    model_reset();
    drive_and_step(rdy_pct);
  endtask

  initial begin
    int pct[3] = '{90, 15, 50};
    model_reset();
    repeat (3) @(negedge clk);
    release_reset(pct[0]);
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        check_all();
        drive_and_step(pct[ph]);
      end
      // Run on until the FIFO holds two entries with a probe staged
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        check_all();
        if (q.size() >= 2 && m_probe) break;
        drive_and_step(pct[ph]);
      end
      // Mid-stream reset: outputs must fall without waiting for an edge
      req_valid = 1'b0;
      out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_probe_en", 64'(probe_en), 64'd0);
      check("async_out_valid", 64'(out_valid), 64'd0);
      check("async_req_ready", 64'(req_ready), 64'd0);
      release_reset(pct[(ph + 1) % 3]);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_all();
      drive_and_step(100);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
